cube_sequencer: RTL and testbench

CUBE_SEQUENCER -- requirements
Module: cube_sequencer

---
 rtl/cube_sequencer.sv | 126 ++++++++++++
 tb/tb_cube_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cube_sequencer.sv
// cube_sequencer: clear/feed/drain job sequencer for a systolic array; ports iClk/iRst, iStart/iAbort/iStall, cfg blocks/cubes/base in; ready/done/clear, lane pattern, shift-out enables, RAM read address out.
module cube_sequencer #(
  parameter int ARRAY_NUM = 3,
  parameter int BLOCK_NUM = 3,
  parameter int CUBE_NUM  = 3,
  parameter int RAM_DEPTH = 2048
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iStart,
  input  logic                           iAbort,
  input  logic                           iStall,
  input  logic [$clog2(BLOCK_NUM+1)-1:0] iCfgBlocks,
  input  logic [$clog2(CUBE_NUM+1)-1:0]  iCfgCubes,
  input  logic [$clog2(RAM_DEPTH)-1:0]   iBaseAddr,
  output logic                           oReady,
  output logic                           oDone,
  output logic                           oClearAcc,
  output logic [ARRAY_NUM-1:0]           oInputPattern,
  output logic [ARRAY_NUM-2:0]           oPassDataLeft,
  output logic                           oAddrValid,
  output logic [$clog2(RAM_DEPTH)-1:0]   oAddr
);
  localparam int BW = $clog2(BLOCK_NUM+1);
  localparam int KW = $clog2(CUBE_NUM+1);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(BLOCK_NUM*ARRAY_NUM+ARRAY_NUM);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, len_q, len_d, feed_last;
  logic [KW-1:0] cube_q, cube_d, cubes_q, cubes_d, cub_c;
  logic [BW-1:0] blk_c;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [ARRAY_NUM-1:0] pat_q, pat_d;
  logic [ARRAY_NUM-2:0] pass_q, pass_d;
  logic av_q, av_d, clr_q, clr_d, done_q, done_d, rdy_q, rdy_d;
  assign blk_c = (iCfgBlocks > BW'(BLOCK_NUM)) ? BW'(BLOCK_NUM) : iCfgBlocks;
  assign cub_c = (iCfgCubes > KW'(CUBE_NUM)) ? KW'(CUBE_NUM) : iCfgCubes;
  assign feed_last = len_q + CW'(ARRAY_NUM-2);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    cube_d = cube_q;
    cubes_d = cubes_q;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: if (iStart) begin
        len_d = CW'(blk_c) * CW'(ARRAY_NUM);
        cubes_d = cub_c;
        cube_d = '0;
        cnt_d = '0;
        ptr_d = iBaseAddr;
        state_d = (blk_c == '0 || cub_c == '0) ? DONE : CLEAR;
      end
      CLEAR: begin
        state_d = FEED;
        cnt_d = '0;
      end
      FEED: if (!iStall) begin
        ptr_d = (cnt_q < len_q) ? ptr_q + AW'(1) : ptr_q;
        state_d = (cnt_q == feed_last) ? DRAIN : FEED;
        cnt_d = (cnt_q == feed_last) ? '0 : cnt_q + CW'(1);
      end
      DRAIN: if (!iStall) begin
        cnt_d = (cnt_q == CW'(ARRAY_NUM-2)) ? '0 : cnt_q + CW'(1);
        cube_d = (cnt_q == CW'(ARRAY_NUM-2)) ? cube_q + KW'(1) : cube_q;
        state_d = (cnt_q != CW'(ARRAY_NUM-2)) ? DRAIN : (cube_q + KW'(1) < cubes_q) ? CLEAR : DONE;
      end
      default: state_d = IDLE;
    endcase
    if (iAbort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d = '0;
      len_d = '0;
      cube_d = '0;
      cubes_d = '0;
      ptr_d = '0;
    end
    // Outputs are decoded from next-state values so they come straight off flops.
    for (int k = 0; k < ARRAY_NUM; k++)
      pat_d[k] = state_d == FEED && int'(cnt_d) >= k && int'(cnt_d) < k + int'(len_d);
    av_d = state_d == FEED && cnt_d < len_d;
    pass_d = {(ARRAY_NUM-1){state_d == DRAIN}};
    clr_d = state_d == CLEAR;
    done_d = state_d == DONE;
    rdy_d = state_d == IDLE;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_q <= '0;
      cube_q <= '0;
      cubes_q <= '0;
      ptr_q <= '0;
      pat_q <= '0;
      pass_q <= '0;
      av_q <= 1'b0;
      clr_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      cube_q <= cube_d;
      cubes_q <= cubes_d;
      ptr_q <= ptr_d;
      pat_q <= pat_d;
      pass_q <= pass_d;
      av_q <= av_d;
      clr_q <= clr_d;
      done_q <= done_d;
      rdy_q <= rdy_d;
    end
  end
  // Stall suppresses the lane/address strobes in the same cycle it is seen.
  assign oInputPattern = pat_q & {ARRAY_NUM{~iStall}};
  assign oPassDataLeft = pass_q & {(ARRAY_NUM-1){~iStall}};
  assign oAddrValid = av_q & ~iStall;
  assign oAddr = ptr_q;
  assign oReady = rdy_q;
  assign oDone = done_q;
  assign oClearAcc = clr_q;
endmodule

// File: tb/tb_cube_sequencer.sv
// tb_cube_sequencer: directed table-driven checks of cube_sequencer job timing, addressing, stall, abort and reset.
module tb_cube_sequencer;
  localparam int BW = 2;
  localparam int KW = 2;
  localparam int AW = 11;
  localparam int RAM_DEPTH = 2048;
  logic iClk = 1'b0, iRst = 1'b1, iStart = 1'b0, iAbort = 1'b0, iStall = 1'b0;
  logic [BW-1:0] iCfgBlocks = '0;
  logic [KW-1:0] iCfgCubes = '0;
  logic [AW-1:0] iBaseAddr = '0;
  logic oReady, oDone, oClearAcc, oAddrValid;
  logic [2:0] oInputPattern;
  logic [1:0] oPassDataLeft;
  logic [AW-1:0] oAddr;
  int checks = 0, failures = 0;
  cube_sequencer dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort), .iStall(iStall),
    .iCfgBlocks(iCfgBlocks), .iCfgCubes(iCfgCubes), .iBaseAddr(iBaseAddr),
    .oReady(oReady), .oDone(oDone), .oClearAcc(oClearAcc), .oInputPattern(oInputPattern),
    .oPassDataLeft(oPassDataLeft), .oAddrValid(oAddrValid), .oAddr(oAddr)
  );
  always #5 iClk = ~iClk;
  typedef struct packed {
    int blk, cub, base, slo, shi;
    bit hold;
    int na, nc, nd, td, tr;
  } vec_t;
  vec_t tbl [9];
  logic [8:0] exp_tr [1:13];
  function automatic logic [8:0] obs();
    return {oClearAcc, oAddrValid, oInputPattern, oPassDataLeft, oDone, oReady};
  endfunction
  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  task automatic start_job(input int blk, input int cub, input int base);
    @(posedge iClk); #1;
    iStart = 1'b1;
    iCfgBlocks = BW'(blk);
    iCfgCubes = KW'(cub);
    iBaseAddr = AW'(base);
    @(posedge iClk); #1;
    iStart = 1'b0;
  endtask
  task automatic run_job(input vec_t v, input string nm);
    int exp_a, na, nc, nd, td, tr, bad;
    exp_a = v.base; na = 0; nc = 0; nd = 0; td = -1; tr = -1; bad = 0;
    start_job(v.blk, v.cub, v.base);
    if (v.hold) begin
      iCfgBlocks = BW'(1);
      iCfgCubes = KW'(3);
      iBaseAddr = AW'(500);
    end
    for (int c = 1; c <= 100; c++) begin
      iStart = v.hold && c < 12;
      iStall = c >= v.slo && c <= v.shi;
      @(negedge iClk);
      if (oAddrValid) begin
        if (int'(oAddr) != exp_a) bad++;
        exp_a = (exp_a + 1) % RAM_DEPTH;
        na++;
      end
      if (oClearAcc) nc++;
      if (oDone) begin nd++; td = c; end
      if (oReady) begin tr = c; break; end
      @(posedge iClk); #1;
    end
    iStart = 1'b0;
    iStall = 1'b0;
    check({nm, " addr_seq_errors"}, bad, 0);
    check({nm, " n_addr"}, na, v.na);
    check({nm, " n_clear"}, nc, v.nc);
    check({nm, " n_done"}, nd, v.nd);
    check({nm, " done_cycle"}, td, v.td);
    check({nm, " ready_cycle"}, tr, v.tr);
  endtask
  initial begin
    int na, nd;
    tbl[0] = '{2, 1, 0,    0, -1, 1'b0, 6,  1, 1, 12, 13};
    tbl[1] = '{1, 2, 2046, 0, -1, 1'b0, 6,  2, 1, 17, 18};
    tbl[2] = '{2, 1, 0,    4, 5,  1'b0, 6,  1, 1, 14, 15};
    tbl[3] = '{2, 0, 7,    0, -1, 1'b0, 0,  0, 1, 1,  2};
    tbl[4] = '{0, 2, 7,    0, -1, 1'b0, 0,  0, 1, 1,  2};
    tbl[5] = '{3, 1, 100,  0, -1, 1'b0, 9,  1, 1, 15, 16};
    tbl[6] = '{3, 3, 10,   0, -1, 1'b0, 27, 3, 1, 43, 44};
    tbl[7] = '{1, 1, 5,    1, 3,  1'b0, 3,  1, 1, 11, 12};
    tbl[8] = '{2, 1, 0,    10, 10, 1'b1, 6, 1, 1, 13, 14};
    exp_tr[1] = 9'b100000000;
    exp_tr[2] = 9'b010010000;
    exp_tr[3] = 9'b010110000;
    for (int c = 4; c <= 7; c++) exp_tr[c] = 9'b011110000;
    exp_tr[8] = 9'b001100000;
    exp_tr[9] = 9'b001000000;
    exp_tr[10] = 9'b000001100;
    exp_tr[11] = 9'b000001100;
    exp_tr[12] = 9'b000000010;
    exp_tr[13] = 9'b000000001;
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    check("reset_outputs", int'(obs()), 9'b000000001);
    check("reset_addr", int'(oAddr), 0);
    // Exact cycle trace of a two-block, one-cube job.
    start_job(2, 1, 0);
    for (int c = 1; c <= 13; c++) begin
      @(negedge iClk);
      check($sformatf("trace_c%0d", c), int'(obs()), int'(exp_tr[c]));
      if (c >= 2 && c <= 7) check($sformatf("trace_addr_c%0d", c), int'(oAddr), c - 2);
      @(posedge iClk); #1;
    end
    foreach (tbl[i]) run_job(tbl[i], $sformatf("vec%0d", i));
    // Abort together with stall in cycle 5.
    start_job(2, 1, 0);
    repeat (3) @(posedge iClk);
    #1 iAbort = 1'b1;
    iStall = 1'b1;
    @(posedge iClk); #1;
    iAbort = 1'b0;
    iStall = 1'b0;
    @(negedge iClk);
    check("abort_outputs", int'(obs()), 9'b000000001);
    check("abort_addr", int'(oAddr), 0);
    na = 0; nd = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge iClk);
      na += int'(oAddrValid);
      nd += int'(oDone);
    end
    check("abort_no_addr", na, 0);
    check("abort_no_done", nd, 0);
    run_job(tbl[0], "after_abort");
    // Reset while draining.
    start_job(2, 1, 0);
    repeat (9) @(posedge iClk);
    @(negedge iClk);
    check("pre_rst_drain", int'(obs()), 9'b000001100);
    @(posedge iClk); #1 iRst = 1'b1;
    @(posedge iClk); #1 iRst = 1'b0;
    @(negedge iClk);
    check("rst_drain_outputs", int'(obs()), 9'b000000001);
    check("rst_drain_addr", int'(oAddr), 0);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge iClk);
      nd += int'(oDone);
    end
    check("rst_no_done", nd, 0);
    run_job(tbl[0], "after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
